// File: rtl/ps2_host_tx_pkg.sv
// Shared constants for the PS/2 host transmit path: FSM encodings, command bytes, parity helper.
package ps2_host_tx_pkg;

    localparam int unsigned DATA_W             = 8;
    localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 750000;
    localparam int unsigned DEF_CNT_W          = 20;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RTS       = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    // Odd parity bit: makes the count of ones over data+parity odd.
    function automatic logic odd_parity(input logic [DATA_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if
    import ps2_host_tx_pkg::*;
();
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;
    logic              tx_done;
    logic              tx_err;

    modport master (output tx_start, output tx_data,
                    input  tx_busy, input tx_done, input tx_err);
    modport slave  (input  tx_start, input tx_data,
                    output tx_busy, output tx_done, output tx_err);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pad plus falling-edge detect; idle-high reset value.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    output logic sync,
    output logic fall_c
);
    logic meta;
    logic prev;

    // Synchronizer chain and one-cycle history for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= pad;
            sync <= meta;
            prev <= sync;
        end
    end

    assign fall_c = prev & ~sync;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, clocked-out odd-parity frame, ACK check.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    ps2_host_tx_if.slave  host,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [8:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             abort;

    logic clk_sync, clk_fall;
    logic data_sync, data_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk    (clk),
        .reset  (reset),
        .pad    (ps2_clk_in),
        .sync   (clk_sync),
        .fall_c (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk    (clk),
        .reset  (reset),
        .pad    (ps2_data_in),
        .sync   (data_sync),
        .fall_c (data_fall_unused)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        abort     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                // A start coinciding with a completion pulse waits one cycle.
                if (host.tx_start && !done_q && !err_q) begin
                    shift_d   = {odd_parity(host.tx_data), host.tx_data};
                    bit_cnt_d = 4'd0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_RTS;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RTS: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (clk_fall) begin
                    cnt_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        bit_cnt_d = 4'd10;
                        state_d   = ST_ACK;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    cnt_d = '0;
                    if (!data_sync) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (clk_fall) begin
                    cnt_d = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        if (abort) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            err_d     = 1'b1;
            state_d   = ST_IDLE;
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            cnt_q     <= cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign host.tx_busy = busy_q;
    assign host.tx_done = done_q;
    assign host.tx_err  = err_q;
endmodule
